// File: rtl/fu_out_queue.sv
// Purpose: DEPTH-entry result buffer between an FU output bundle and writeback/ROB completion, optionally one destination per beat.
// Latency: one cycle from push to head visibility; outputs are combinational reads of registered storage.
// Backpressure: in_ready = !full, regardless of out_ready; a beat is held stable until out_ready; flush drops everything.
`timescale 1ns/1ps
module fu_out_queue #(
   parameter int INST_ID_BITS = 8,
   parameter int PRN_BITS     = 6,
   parameter int MAX_OPERANDS = 3,
   parameter int DEPTH        = 4,
   parameter int SERIALIZE    = 0
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    flush,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [INST_ID_BITS-1:0]                 in_inst_id,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   in_prn,
   input  logic [MAX_OPERANDS-1:0][63:0]           in_data,
   input  logic [MAX_OPERANDS-1:0]                 in_op_valid,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [INST_ID_BITS-1:0]                 out_inst_id,
   output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   out_prn,
   output logic [MAX_OPERANDS-1:0][63:0]           out_data,
   output logic [MAX_OPERANDS-1:0]                 out_op_valid,
   output logic                                    out_last,
   output logic [$clog2(DEPTH+1)-1:0]              count,
   output logic                                    full,
   output logic                                    empty
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int SLOT_W = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;

   // Beat FSM: FIRST means the head's beat slot is its lowest valid slot,
   // NEXT means beat_q holds the slot chosen after a non-final handshake.
   localparam logic [0:0] BEAT_FIRST = 1'b0;
   localparam logic [0:0] BEAT_NEXT  = 1'b1;

   typedef struct packed {
      logic [INST_ID_BITS-1:0]               id;
      logic [MAX_OPERANDS-1:0]               opv;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
      logic [MAX_OPERANDS-1:0][63:0]         data;
   } entry_t;

   entry_t              mem_q [DEPTH];
   entry_t              mem_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [0:0]          beat_st_q, beat_st_d;
   logic [SLOT_W-1:0]   beat_q, beat_d;

   entry_t              head;
   logic                push;
   logic                pop;
   logic [SLOT_W-1:0]   first_slot;
   logic [SLOT_W-1:0]   cur_slot;
   logic [SLOT_W-1:0]   next_slot;
   logic                has_higher;

   assign count     = count_q;
   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = !full;
   assign out_valid = !empty && !flush;
   assign head      = mem_q[rd_ptr_q];
   assign push      = in_valid && in_ready && !flush;
   // out_last is constantly 1 for whole-entry beats, so this covers both modes.
   assign pop       = out_valid && out_ready && out_last;

   // Locate the current beat slot of the head and the next valid slot above it.
   always_comb begin
      first_slot = '0;
      next_slot  = '0;
      has_higher = 1'b0;
      for (int i = MAX_OPERANDS-1; i >= 0; i--) begin
         if (head.opv[i]) first_slot = SLOT_W'(i);
      end
      cur_slot = (beat_st_q == BEAT_NEXT) ? beat_q : first_slot;
      for (int i = MAX_OPERANDS-1; i >= 0; i--) begin
         if (head.opv[i] && (i > int'(cur_slot))) begin
            next_slot  = SLOT_W'(i);
            has_higher = 1'b1;
         end
      end
   end

   // Present the head entry (or one slot of it) while a beat is valid, zeros otherwise.
   always_comb begin
      out_inst_id  = '0;
      out_prn      = '0;
      out_data     = '0;
      out_op_valid = '0;
      out_last     = 1'b0;
      if (out_valid) begin
         out_inst_id = head.id;
         if (SERIALIZE == 0) begin
            out_prn      = head.prn;
            out_data     = head.data;
            out_op_valid = head.opv;
            out_last     = 1'b1;
         end else begin
            out_prn[0]      = head.prn[cur_slot];
            out_data[0]     = head.data[cur_slot];
            out_op_valid[0] = head.opv[cur_slot];
            out_last        = !has_higher;
         end
      end
   end

   // Next-state: storage write, pointer/count update, beat pointer advance; flush wins.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      beat_st_d = beat_st_q;
      beat_d    = beat_q;
      if (push) begin
         mem_d[wr_ptr_q].id   = in_inst_id;
         mem_d[wr_ptr_q].opv  = in_op_valid;
         mem_d[wr_ptr_q].prn  = in_prn;
         mem_d[wr_ptr_q].data = in_data;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      if (out_valid && out_ready) begin
         if (out_last) begin
            beat_st_d = BEAT_FIRST;
            beat_d    = '0;
         end else begin
            beat_st_d = BEAT_NEXT;
            beat_d    = next_slot;
         end
      end
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         beat_st_d = BEAT_FIRST;
         beat_d    = '0;
      end
   end

   // State registers; reset discards any partially serialised entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         beat_st_q <= BEAT_FIRST;
         beat_q    <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         beat_st_q <= beat_st_d;
         beat_q    <= beat_d;
      end
   end

endmodule

// File: tb/tb_fu_out_queue.sv
// Bench for fu_out_queue: one whole-entry instance and one serialising instance.
// Scoreboard queues hold expected beats; a vector table covers the fill/drain case.
`timescale 1ns/1ps
module tb_fu_out_queue;

   typedef struct packed {
      logic [7:0]       id;
      logic [2:0]       opv;
      logic [2:0][5:0]  prn;
      logic [2:0][63:0] data;
      logic             last;
   } beat_t;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       ev;
      logic [7:0] eid;
      int         ecnt;
      logic       efull;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             iv0 = 0, iv1 = 0, ordy0 = 0, ordy1 = 0, fl0 = 0, fl1 = 0;
   logic [7:0]       in_id = '0;
   logic [2:0][5:0]  in_prn = '0;
   logic [2:0][63:0] in_data = '0;
   logic [2:0]       in_opv = '0;

   logic             irdy0, ov0, olast0, full0, empty0;
   logic [7:0]       oid0;
   logic [2:0][5:0]  oprn0;
   logic [2:0][63:0] odata0;
   logic [2:0]       oopv0, cnt0;
   logic             irdy1, ov1, olast1, full1, empty1;
   logic [7:0]       oid1;
   logic [2:0][5:0]  oprn1;
   logic [2:0][63:0] odata1;
   logic [2:0]       oopv1, cnt1;

   fu_out_queue #(.INST_ID_BITS(8), .PRN_BITS(6), .MAX_OPERANDS(3), .DEPTH(4), .SERIALIZE(0)) u0 (
      .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(irdy0), .in_inst_id(in_id),
      .in_prn(in_prn), .in_data(in_data), .in_op_valid(in_opv), .out_valid(ov0), .out_ready(ordy0),
      .out_inst_id(oid0), .out_prn(oprn0), .out_data(odata0), .out_op_valid(oopv0), .out_last(olast0),
      .count(cnt0), .full(full0), .empty(empty0));

   fu_out_queue #(.INST_ID_BITS(8), .PRN_BITS(6), .MAX_OPERANDS(3), .DEPTH(4), .SERIALIZE(1)) u1 (
      .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(irdy1), .in_inst_id(in_id),
      .in_prn(in_prn), .in_data(in_data), .in_op_valid(in_opv), .out_valid(ov1), .out_ready(ordy1),
      .out_inst_id(oid1), .out_prn(oprn1), .out_data(odata1), .out_op_valid(oopv1), .out_last(olast1),
      .count(cnt1), .full(full1), .empty(empty1));

   int    total = 0;
   int    bad = 0;
   int    mcount [2];
   beat_t sb0 [$];
   beat_t sb1 [$];
   vec_t  tbl [10];

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive a generic entry whose fields are derived from its id.
   task automatic set_in(input logic [7:0] id, input logic [2:0] opv);
      in_id  = id;
      in_opv = opv;
      for (int k = 0; k < 3; k++) begin
         in_prn[k]  = 6'((int'(id) * 3 + k + 1) % 64);
         in_data[k] = {8'(k), 24'h0, 24'hA5A5A5, id};
      end
   endtask

   // Expected beats for an accepted push on instance d.
   task automatic push_beats(input int d);
      beat_t b;
      if (d == 0) begin
         b = '{id: in_id, opv: in_opv, prn: in_prn, data: in_data, last: 1'b1};
         sb0.push_back(b);
      end else if (in_opv == 3'b000) begin
         b = '0;
         b.id = in_id; b.prn[0] = in_prn[0]; b.data[0] = in_data[0]; b.last = 1'b1;
         sb1.push_back(b);
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (in_opv[k]) begin
               b = '0;
               b.id = in_id; b.opv = 3'b001; b.prn[0] = in_prn[k]; b.data[0] = in_data[k];
               b.last = 1'b1;
               for (int j = k + 1; j < 3; j++) if (in_opv[j]) b.last = 1'b0;
               sb1.push_back(b);
            end
         end
      end
   endtask

   task automatic model_step(input int d, input logic ov, input logic olast, input logic fl_o,
                             input logic em, input logic irdy, input logic [7:0] oid,
                             input logic [2:0] oopv, input logic [2:0][5:0] oprn,
                             input logic [2:0][63:0] odata, input logic [2:0] cnt,
                             input logic iv, input logic ordy, input logic fl);
      int    pre;
      logic  exp_v;
      beat_t hd;
      pre   = mcount[d];
      exp_v = (pre > 0) && !fl;
      chk("count", 192'(cnt), 192'(pre));
      chk("full", 192'(fl_o), 192'(pre == 4));
      chk("empty", 192'(em), 192'(pre == 0));
      chk("in_ready", 192'(irdy), 192'(pre != 4));
      chk("out_valid", 192'(ov), 192'(exp_v));
      if (exp_v) begin
         if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            chk("sb_nonempty", 192'(0), 192'(1));
         end else begin
            hd = (d == 0) ? sb0[0] : sb1[0];
            chk("out_id", 192'(oid), 192'(hd.id));
            chk("out_opv", 192'(oopv), 192'(hd.opv));
            chk("out_prn", 192'(oprn), 192'(hd.prn));
            chk("out_data", odata, hd.data);
            chk("out_last", 192'(olast), 192'(hd.last));
            if (ordy) begin
               if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
               if (hd.last) mcount[d]--;
            end
         end
      end else begin
         chk("idle_fields", 192'({oid, oopv, oprn, olast}), 192'(0));
         chk("idle_data", odata, 192'(0));
      end
      if (iv && (pre < 4) && !fl) begin
         push_beats(d);
         mcount[d]++;
      end
      if (fl) begin
         mcount[d] = 0;
         if (d == 0) sb0.delete(); else sb1.delete();
      end
   endtask

   task automatic cycle();
      #1;
      model_step(0, ov0, olast0, full0, empty0, irdy0, oid0, oopv0, oprn0, odata0, cnt0, iv0, ordy0, fl0);
      model_step(1, ov1, olast1, full1, empty1, irdy1, oid1, oopv1, oprn1, odata1, cnt1, iv1, ordy1, fl1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ov0"}, 192'(ov0), 192'(0));
      chk({tag, "_ov1"}, 192'(ov1), 192'(0));
      chk({tag, "_rdy"}, 192'({irdy0, irdy1}), 192'(2'b11));
      chk({tag, "_empty"}, 192'({empty0, empty1}), 192'(2'b11));
      chk({tag, "_full"}, 192'({full0, full1}), 192'(0));
      chk({tag, "_cnt"}, 192'({cnt0, cnt1}), 192'(0));
      chk({tag, "_last"}, 192'({olast0, olast1}), 192'(0));
      chk({tag, "_f0"}, 192'({oid0, oopv0, oprn0}), 192'(0));
      chk({tag, "_f1"}, 192'({oid1, oopv1, oprn1}), 192'(0));
      chk({tag, "_d0"}, odata0, 192'(0));
      chk({tag, "_d1"}, odata1, 192'(0));
   endtask

   task automatic clear_model();
      mcount[0] = 0;
      mcount[1] = 0;
      sb0.delete();
      sb1.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        iv  id    ordy ev  eid   cnt full
      tbl[0] = '{1, 8'd1, 0,   0,  8'd0, 0,  0};
      tbl[1] = '{1, 8'd2, 0,   1,  8'd1, 1,  0};
      tbl[2] = '{1, 8'd3, 0,   1,  8'd1, 2,  0};
      tbl[3] = '{1, 8'd4, 0,   1,  8'd1, 3,  0};
      tbl[4] = '{1, 8'd5, 0,   1,  8'd1, 4,  1};
      tbl[5] = '{1, 8'd5, 1,   1,  8'd1, 4,  1};
      tbl[6] = '{0, 8'd0, 1,   1,  8'd2, 3,  0};
      tbl[7] = '{0, 8'd0, 1,   1,  8'd3, 2,  0};
      tbl[8] = '{0, 8'd0, 1,   1,  8'd4, 1,  0};
      tbl[9] = '{0, 8'd0, 1,   0,  8'd0, 0,  0};
      clear_model();

      #1 rst = 1'b0;
      #1 check_reset_vals("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Fill to full with the consumer stalled, refuse the 5th, then drain.
      for (int i = 0; i < 10; i++) begin
         iv0 = tbl[i].iv;
         set_in(tbl[i].id, 3'b011);
         ordy0 = tbl[i].ordy;
         #1;
         chk("tbl_valid", 192'(ov0), 192'(tbl[i].ev));
         chk("tbl_id", 192'(oid0), 192'(tbl[i].eid));
         chk("tbl_count", 192'(cnt0), 192'(tbl[i].ecnt));
         chk("tbl_full", 192'(full0), 192'(tbl[i].efull));
         chk("tbl_in_ready", 192'(irdy0), 192'(!tbl[i].efull));
         cycle();
      end

      // Streaming: push and pop every cycle, ids 0..9, wrapping the pointers.
      for (int i = 0; i < 10; i++) begin
         iv0 = 1'b1; ordy0 = 1'b1;
         set_in(8'(i), 3'(i % 8));
         #1;
         if (i > 0) begin
            chk("stream_id", 192'(oid0), 192'(i - 1));
            chk("stream_cnt", 192'(cnt0), 192'(1));
         end
         cycle();
      end
      iv0 = 1'b0;
      repeat (2) cycle();

      // Serialising: sparse slots then an entry with no valid slots.
      iv1 = 1'b1; ordy1 = 1'b0;
      in_id = 8'd7; in_opv = 3'b101;
      in_prn = '{6'd9, 6'h21, 6'd5};
      in_data = '{64'hB, 64'hDEAD, 64'hA};
      cycle();
      in_id = 8'd8; in_opv = 3'b000; in_prn = '0; in_data = '0;
      cycle();
      iv1 = 1'b0; ordy1 = 1'b1;
      #1;
      chk("ser_b1_prn", 192'(oprn1[0]), 192'(5));
      chk("ser_b1_data", 192'(odata1[0]), 192'(64'hA));
      chk("ser_b1_last", 192'(olast1), 192'(0));
      cycle();
      chk("ser_b2_prn", 192'(oprn1[0]), 192'(9));
      chk("ser_b2_last", 192'(olast1), 192'(1));
      cycle();
      chk("ser_b3_id", 192'(oid1), 192'(8));
      chk("ser_b3_opv", 192'(oopv1), 192'(0));
      repeat (2) cycle();

      // Serialising with a stall between beats.
      iv1 = 1'b1; ordy1 = 1'b0;
      set_in(8'd9, 3'b111);
      cycle();
      iv1 = 1'b0;
      ordy1 = 1'b1; cycle();
      ordy1 = 1'b0; cycle();
      chk("stall_hold_prn", 192'(oprn1[0]), 192'(in_prn[1]));
      ordy1 = 1'b0; cycle();
      ordy1 = 1'b1; cycle();
      ordy1 = 1'b1; cycle();
      cycle();

      // Flush with a concurrent push.
      iv0 = 1'b1; ordy0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(8'(40 + i), 3'b001);
         cycle();
      end
      fl0 = 1'b1;
      set_in(8'd43, 3'b111);
      #1 chk("flush_ov", 192'(ov0), 192'(0));
      cycle();
      fl0 = 1'b0; iv0 = 1'b0; ordy0 = 1'b1;
      #1;
      chk("flush_cnt", 192'(cnt0), 192'(0));
      chk("flush_empty", 192'(empty0), 192'(1));
      repeat (3) cycle();

      // Async reset in the middle of a serialised entry.
      iv1 = 1'b1; ordy1 = 1'b0;
      set_in(8'd20, 3'b011); cycle();
      set_in(8'd21, 3'b001); cycle();
      iv1 = 1'b0; ordy1 = 1'b1; cycle();
      ordy1 = 1'b0;
      #1 chk("pre_rst_cnt", 192'(cnt1), 192'(2));
      #2 rst = 1'b0;
      #1 check_reset_vals("midrst");
      clear_model();
      @(negedge clk);
      rst = 1'b1;
      iv1 = 1'b1; ordy1 = 1'b0;
      set_in(8'd30, 3'b010);
      cycle();
      iv1 = 1'b0; ordy1 = 1'b1;
      #1;
      chk("post_rst_id", 192'(oid1), 192'(30));
      chk("post_rst_prn", 192'(oprn1[0]), 192'(in_prn[1]));
      chk("post_rst_last", 192'(olast1), 192'(1));
      repeat (2) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
